// File: rtl/skew_add_stage.sv
// skew_add_stage: one systolic vector-sum stage; delays a by DELAY cycles, then registers a_dly + b.
// Optional SKEW_ADD_VALID_EN adds an in_valid/out_valid sideband that tracks the a->sum latency.
module skew_add_stage #(
    parameter int DELAY = 0,
    parameter int W_A   = 32,
    parameter int W_B   = 33,
    parameter int W_S   = 33
) (
    input  logic           Clock,
    input  logic           Reset,
`ifdef SKEW_ADD_VALID_EN
    input  logic           in_valid,
    output logic           out_valid,
`endif
    input  logic [W_A-1:0] a,
    input  logic [W_B-1:0] b,
    output logic [W_A-1:0] a_dly,
    output logic [W_S-1:0] sum
);
    localparam int W_X = ((W_A > W_B) ? W_A : W_B) + 1;

    if (DELAY < 0) begin : g_bad_delay
        $error("skew_add_stage: DELAY must be >= 0");
    end

    if (DELAY == 0) begin : g_pass
        assign a_dly = a;
    end else begin : g_chain
        logic [W_A-1:0] chain [DELAY];
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                for (int i = 0; i < DELAY; i++) chain[i] <= '0;
            end else begin
                chain[0] <= a;
                for (int i = 1; i < DELAY; i++) chain[i] <= chain[i-1];
            end
        end
        assign a_dly = chain[DELAY-1];
    end

    // Full-precision add, then keep the low W_S bits (zero-extend or wrap).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) sum <= '0;
        else       sum <= W_S'(W_X'(a_dly) + W_X'(b));
    end

`ifdef SKEW_ADD_VALID_EN
    localparam int W_V = (DELAY < 0 ? 0 : DELAY) + 1;
    logic [W_V-1:0] vchain;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) vchain <= '0;
        else       vchain <= (vchain << 1) | W_V'(in_valid);
    end
    assign out_valid = vchain[W_V-1];
`endif
endmodule

// File: tb/tb_skew_add_stage.sv
// tb_skew_add_stage: table-driven and sequence checks of skew_add_stage across several parameterisations.
module tb_skew_add_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0] a0, am, a3, a2;
    logic [8:0] b0, b3;
    logic [7:0] bm, b2;
    logic [7:0] ad0, adm9, adm8, ad3, ad2;
    logic [8:0] s0, sm9, s3, s2;
    logic [7:0] sm8;
    logic in_valid, out_valid;

    int errs = 0;
    int checks = 0;

    skew_add_stage #(.DELAY(0), .W_A(8), .W_B(9), .W_S(9)) u0 (
        .Clock(clk), .Reset(rst),
`ifdef SKEW_ADD_VALID_EN
        .in_valid(1'b0), .out_valid(),
`endif
        .a(a0), .b(b0), .a_dly(ad0), .sum(s0));
    skew_add_stage #(.DELAY(0), .W_A(8), .W_B(8), .W_S(9)) um9 (
        .Clock(clk), .Reset(rst),
`ifdef SKEW_ADD_VALID_EN
        .in_valid(1'b0), .out_valid(),
`endif
        .a(am), .b(bm), .a_dly(adm9), .sum(sm9));
    skew_add_stage #(.DELAY(0), .W_A(8), .W_B(8), .W_S(8)) um8 (
        .Clock(clk), .Reset(rst),
`ifdef SKEW_ADD_VALID_EN
        .in_valid(1'b0), .out_valid(),
`endif
        .a(am), .b(bm), .a_dly(adm8), .sum(sm8));
    skew_add_stage #(.DELAY(3), .W_A(8), .W_B(9), .W_S(9)) u3 (
        .Clock(clk), .Reset(rst),
`ifdef SKEW_ADD_VALID_EN
        .in_valid(1'b0), .out_valid(),
`endif
        .a(a3), .b(b3), .a_dly(ad3), .sum(s3));
    skew_add_stage #(.DELAY(2), .W_A(8), .W_B(8), .W_S(9)) u2 (
        .Clock(clk), .Reset(rst),
`ifdef SKEW_ADD_VALID_EN
        .in_valid(in_valid), .out_valid(out_valid),
`endif
        .a(a2), .b(b2), .a_dly(ad2), .sum(s2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [8:0] b;
        logic [8:0] s0;
        logic [8:0] s9;
        logic [7:0] s8;
    } vec_t;
    vec_t tv [6];
    int exp4 [8];

    initial begin
        tv[0] = '{a: 8'd200, b: 9'd300, s0: 9'd500, s9: 9'd244, s8: 8'd244};
        tv[1] = '{a: 8'd255, b: 9'd255, s0: 9'd510, s9: 9'd510, s8: 8'd254};
        tv[2] = '{a: 8'd0,   b: 9'd0,   s0: 9'd0,   s9: 9'd0,   s8: 8'd0};
        tv[3] = '{a: 8'd255, b: 9'd511, s0: 9'd254, s9: 9'd510, s8: 8'd254};
        tv[4] = '{a: 8'd1,   b: 9'd256, s0: 9'd257, s9: 9'd1,   s8: 8'd1};
        tv[5] = '{a: 8'd128, b: 9'd128, s0: 9'd256, s9: 9'd256, s8: 8'd0};
        exp4 = '{0, 10, 10, 11, 12, 13, 14, 10};

        rst = 1'b1;
        a0 = '0; b0 = '0; am = '0; bm = '0; a3 = '0; b3 = '0; a2 = '0; b2 = '0;
        in_valid = 1'b0;
        @(negedge clk);
        a0 = 8'd42;
        #1;
        chk("rst_s0", 32'(s0), 32'd0);
        chk("rst_s3", 32'(s3), 32'd0);
        chk("rst_ad3", 32'(ad3), 32'd0);
        chk("rst_s2", 32'(s2), 32'd0);
        chk("rst_ad0_tracks", 32'(ad0), 32'd42);
`ifdef SKEW_ADD_VALID_EN
        chk("rst_out_valid", 32'(out_valid), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a0 = tv[i].a; b0 = tv[i].b; am = tv[i].a; bm = tv[i].b[7:0];
            @(negedge clk);
            chk($sformatf("tv%0d_s0", i), 32'(s0), 32'(tv[i].s0));
            chk($sformatf("tv%0d_ad0", i), 32'(ad0), 32'(tv[i].a));
            chk($sformatf("tv%0d_s9", i), 32'(sm9), 32'(tv[i].s9));
            chk($sformatf("tv%0d_s8", i), 32'(sm8), 32'(tv[i].s8));
        end

        // DELAY=3 single pulse
        @(negedge clk);
        a3 = 8'd5; b3 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            a3 = '0;
            chk($sformatf("pulse_ad3_k%0d", k), 32'(ad3), (k == 3) ? 32'd5 : 32'd0);
            chk($sformatf("pulse_s3_k%0d", k), 32'(s3), (k == 4) ? 32'd5 : 32'd0);
        end

        // DELAY=2 streaming
        @(negedge clk);
        a2 = 8'd1; b2 = 8'd10;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            a2 = (k < 4) ? 8'(k + 1) : 8'd0;
            chk($sformatf("stream_s2_k%0d", k), 32'(s2), 32'(exp4[k]));
        end

        // Asynchronous reset mid-stream
        b2 = '0;
        a2 = 8'd9;
        repeat (3) @(negedge clk);
        chk("pre_rst_s2", 32'(s2), 32'd9);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_s2", 32'(s2), 32'd0);
        chk("async_rst_ad2", 32'(ad2), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_rst_s2", 32'(s2), 32'd0);
        chk("hold_rst_ad2", 32'(ad2), 32'd0);
`ifdef SKEW_ADD_VALID_EN
        chk("hold_rst_out_valid", 32'(out_valid), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        a2 = 8'd3;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            a2 = '0;
            chk($sformatf("release_s2_k%0d", k), 32'(s2), (k == 3) ? 32'd3 : 32'd0);
        end

`ifdef SKEW_ADD_VALID_EN
        @(negedge clk);
        chk("valid_idle", 32'(out_valid), 32'd0);
        in_valid = 1'b1; a2 = 8'd7; b2 = 8'd1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0; a2 = '0;
            chk($sformatf("valid_k%0d", k), 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) chk("valid_sum", 32'(s2), 32'd8);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
